// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader
// Description : Consumer engine for the team's registered-read synchronous FIFO.
//               Waits for a burst's worth of records, requests the shared output
//               path from the arbiter and drains the burst over valid/ready.
//               The optional partial-burst flush is built with the macro
//               FIFO_BURST_READER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DW      = 8,
    parameter int AW      = 3,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] fifo_rdata,
    input  logic [AW-1:0] fifo_records,
    output logic          fifo_re,
    output logic          arb_req,
    input  logic          arb_grant,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_POP   = 3'd2,
        S_LATCH = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [AW-1:0] BURST_AW     = AW'(BURST);
    localparam logic [7:0]    TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] count;
    logic [AW-1:0] len;
    logic          last_word;
    logic          tmo_fire;

    assign last_word = (count == len - 1'b1);
    assign fifo_re   = (state == S_POP);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Only a partially filled FIFO seen from IDLE ages toward a flush.
    assign tmo_fire = (state == S_IDLE) && (fifo_records != '0) &&
                      (fifo_records < BURST_AW) && (tmo_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= 8'd0;
        end else if (state != S_IDLE || fifo_records == '0 || tmo_fire) begin
            tmo_cnt <= 8'd0;
        end else if (fifo_records < BURST_AW) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`else
    logic unused_timeout;

    // The flush interval only matters when the flush counter is built.
    assign unused_timeout = ^TIMEOUT_LAST;
    assign tmo_fire       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (fifo_records >= BURST_AW || tmo_fire) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (arb_grant) begin
                    state_next = S_POP;
                end
            end
            S_POP:   state_next = S_LATCH;
            S_LATCH: state_next = S_HOLD;
            S_HOLD: begin
                if (out_ready) begin
                    state_next = last_word ? S_IDLE : S_POP;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arb_req   <= 1'b0;
            count     <= '0;
            len       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            // Request stays up from REQ through the final accept.
            arb_req <= (state_next != S_IDLE);
            case (state)
                S_REQ: begin
                    if (arb_grant) begin
                        len   <= (fifo_records < BURST_AW) ? fifo_records : BURST_AW;
                        count <= '0;
                    end
                end
                S_LATCH: begin
                    out_data  <= fifo_rdata;
                    out_valid <= 1'b1;
                    out_last  <= last_word;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        count     <= count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_burst_reader
// Description : Directed bench for fifo_burst_reader with a registered-read FIFO
//               model and an arbiter with programmable grant delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] fifo_rdata;
    logic [AW-1:0] fifo_records;
    logic          fifo_re;
    logic          arb_req;
    logic          arb_grant = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    logic          wr_en;
    logic [DW-1:0] wr_data;
    int            grant_delay;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            re_cnt = 0;

    int n_checks = 0;
    int n_errors = 0;

    fifo_burst_reader #(.DW(DW), .AW(AW), .BURST(4), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_rdata   (fifo_rdata),
        .fifo_records (fifo_records),
        .fifo_re      (fifo_re),
        .arb_req      (arb_req),
        .arb_grant    (arb_grant),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    // Registered-read FIFO: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        int sz;
        if (reset) begin
            fifo_q.delete();
            fifo_rdata   <= '0;
            fifo_records <= '0;
        end else begin
            if (fifo_re) fifo_rdata <= fifo_q.pop_front();
            if (wr_en) fifo_q.push_back(wr_data);
            sz = fifo_q.size();
            fifo_records <= sz[AW-1:0];
        end
    end

    // Arbiter: grants grant_delay cycles after seeing a request, holds while requested.
    always begin
        @(posedge clk);
        #2;
        if (!arb_req) begin
            arb_grant = 1'b0;
        end else if (!arb_grant) begin
            repeat (grant_delay) @(posedge clk);
            if (grant_delay > 0) #2;
            arb_grant = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
        if (fifo_re) re_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_count(input int target, input string tag);
        int n = 0;
        while (got_d.size() < target && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(got_d.size()), 32'(target));
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic check_burst(input int base, input int n, input logic [DW-1:0] first,
                               input logic [DW-1:0] step);
        for (int i = 0; i < n; i++) begin
            if (base + i < got_d.size()) begin
                check("burst_data", {24'd0, got_d[base+i]}, {24'd0, 8'(first + i * step)});
                check("burst_last", {31'd0, got_l[base+i]}, {31'd0, (i == n - 1)});
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_re"},    {31'd0, fifo_re},   32'd0);
        check({tag, "_req"},   {31'd0, arb_req},   32'd0);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_last"},  {31'd0, out_last},  32'd0);
        check({tag, "_data"},  {24'd0, out_data},  32'd0);
    endtask

    initial begin
        int base;
        int re_base;
        int n;
        logic [DW-1:0] d;
        int rc;
        logic ok;
        logic seen;

        reset       = 1'b1;
        out_ready   = 1'b1;
        wr_en       = 1'b0;
        wr_data     = '0;
        grant_delay = 0;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Full burst with a free-running sink.
        base = got_d.size();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_count(base + 4, "full_count");
        check_burst(base, 4, 8'h11, 8'h11);
        check("full_req_drop", {31'd0, arb_req}, 32'd0);
        check("full_records", {29'd0, fifo_records}, 32'd0);
        check("full_valid_drop", {31'd0, out_valid}, 32'd0);

        // Five cycles of backpressure in every HOLD.
        base      = got_d.size();
        re_base   = re_cnt;
        out_ready = 1'b0;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        for (int w = 0; w < 4; w++) begin
            wait_valid("bp_valid");
            d  = out_data;
            rc = re_cnt;
            ok = 1'b1;
            repeat (5) begin
                tick();
                if (!out_valid || out_data !== d) ok = 1'b0;
            end
            check("bp_stable", {31'd0, ok}, 32'd1);
            check("bp_no_extra_re", 32'(re_cnt), 32'(rc));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        wait_count(base + 4, "bp_count");
        check_burst(base, 4, 8'hA1, 8'h01);
        check("bp_re_total", 32'(re_cnt - re_base), 32'd4);
        out_ready = 1'b1;

        // Grant withheld for ten cycles.
        grant_delay = 10;
        base        = got_d.size();
        re_base     = re_cnt;
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        n = 0;
        while (!arb_grant && n < 40) begin
            tick();
            n++;
        end
        check("dg_grant_seen", {31'd0, arb_grant}, 32'd1);
        check("dg_no_early_re", 32'(re_cnt), 32'(re_base));
        check("dg_pop_after_grant", {31'd0, fifo_re}, 32'd1);
        check("dg_valid_pop", {31'd0, out_valid}, 32'd0);
        tick();
        check("dg_valid_latch", {31'd0, out_valid}, 32'd0);
        tick();
        check("dg_first_valid", {31'd0, out_valid}, 32'd1);
        wait_count(base + 4, "dg_count");
        check_burst(base, 4, 8'hB1, 8'h01);
        grant_delay = 0;

        // Six records: one burst of four, two left behind until topped up.
        base = got_d.size();
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); push(8'hC5); push(8'hC6);
        wait_count(base + 4, "os_first_count");
        check_burst(base, 4, 8'hC1, 8'h01);
        check("os_req_drop", {31'd0, arb_req}, 32'd0);
        check("os_leftover", {29'd0, fifo_records}, 32'd2);
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (arb_req) seen = 1'b1;
        end
        check("os_no_early_req", {31'd0, seen}, 32'd0);
        push(8'hC7); push(8'hC8);
        wait_count(base + 8, "os_second_count");
        check_burst(base + 4, 4, 8'hC5, 8'h01);

        // Reset while the second word waits in HOLD.
        base      = got_d.size();
        out_ready = 1'b0;
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
        wait_valid("rst_word1");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid("rst_word2");
        check("rst_word2_data", {24'd0, out_data}, 32'hE2);
        reset = 1'b1;
        tick();
        check_idle_outputs("midrst");
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        check("rst_no_resend", 32'(got_d.size()), 32'(base + 1));
        check("rst_records", {29'd0, fifo_records}, 32'd0);
        check("rst_req_idle", {31'd0, arb_req}, 32'd0);

        // Partial burst of two records.
        base = got_d.size();
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        push(8'hD1);
        n = 0;
        push(8'hD2);
        n = 1;
        while (!arb_req && n < 40) begin
            tick();
            n++;
        end
        check("tmo_latency", 32'(n), 32'd16);
        wait_count(base + 2, "tmo_count");
        check_burst(base, 2, 8'hD1, 8'h01);
        check("tmo_records", {29'd0, fifo_records}, 32'd0);
`else
        push(8'hD1);
        push(8'hD2);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (arb_req) seen = 1'b1;
        end
        check("partial_no_req", {31'd0, seen}, 32'd0);
        check("partial_records", {29'd0, fifo_records}, 32'd2);
        check("partial_no_words", 32'(got_d.size()), 32'(base));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
